// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the data stage (MEM).
// Round-robin on contention, registered memory strobes, sticky busy-timeout flag.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IREAD,
  input  logic [ADDR_W-1:0] IADDRESS,
  output logic [DATA_W-1:0] IREADDATA,
  output logic              IBUSYWAIT,
  input  logic              DREAD,
  input  logic              DWRITE,
  input  logic [ADDR_W-1:0] DADDRESS,
  input  logic [DATA_W-1:0] DWRITEDATA,
  output logic [DATA_W-1:0] DREADDATA,
  output logic              DBUSYWAIT,
  output logic              MREAD,
  output logic              MWRITE,
  output logic [ADDR_W-1:0] MADDRESS,
  output logic [DATA_W-1:0] MWRITEDATA,
  input  logic [DATA_W-1:0] MREADDATA,
  input  logic              MBUSYWAIT,
  output logic              ERROR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IGNT = 2'd1;
  localparam logic [1:0] S_DGNT = 2'd2;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  logic [1:0]        r_state;
  logic              r_last;
  logic              r_first;
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_error;
  logic [DATA_W-1:0] r_ireaddata;
  logic [DATA_W-1:0] r_dreaddata;
  logic              r_mread;
  logic              r_mwrite;
  logic [ADDR_W-1:0] r_maddress;
  logic [DATA_W-1:0] r_mwritedata;

  logic              w_ireq;
  logic              w_dreq;
  logic              w_granted;
  logic              w_done;
  logic              w_idone;
  logic              w_ddone;
  logic              w_start;
  logic [1:0]        w_next;
  logic [TCNT_W-1:0] w_tcnt_nxt;

  assign w_ireq    = IREAD;
  assign w_dreq    = DREAD | DWRITE;
  assign w_granted = (r_state != S_IDLE);
  // Memory gets the first grant cycle to raise MBUSYWAIT before completion is judged.
  assign w_done    = w_granted & ~r_first & ~MBUSYWAIT;
  assign w_idone   = (r_state == S_IGNT) & w_done;
  assign w_ddone   = (r_state == S_DGNT) & w_done;
  assign w_start   = (w_next != S_IDLE) & ((r_state == S_IDLE) | w_done);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ireq && (!w_dreq || r_last)) w_next = S_IGNT;
        else if (w_dreq)                    w_next = S_DGNT;
      end
      S_IGNT:  if (w_done) w_next = w_dreq ? S_DGNT : S_IDLE;
      S_DGNT:  if (w_done) w_next = w_ireq ? S_IGNT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tcnt_nxt = r_tcnt;
    if (w_done)
      w_tcnt_nxt = '0;
    else if (w_granted && MBUSYWAIT && (r_tcnt != TCNT_MAX))
      w_tcnt_nxt = r_tcnt + TCNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_first      <= 1'b0;
      r_tcnt       <= '0;
      r_error      <= 1'b0;
      r_ireaddata  <= '0;
      r_dreaddata  <= '0;
      r_mread      <= 1'b0;
      r_mwrite     <= 1'b0;
      r_maddress   <= '0;
      r_mwritedata <= '0;
    end else begin
      r_state <= w_next;
      r_first <= w_start;
      r_tcnt  <= w_tcnt_nxt;
      if (w_tcnt_nxt == TCNT_MAX) r_error <= 1'b1;
      // Strobes and mux are latched at grant start and held until done, even if the request drops.
      if (w_start) begin
        if (w_next == S_IGNT) begin
          r_mread    <= 1'b1;
          r_mwrite   <= 1'b0;
          r_maddress <= IADDRESS;
        end else begin
          r_mread      <= ~DWRITE;
          r_mwrite     <= DWRITE;
          r_maddress   <= DADDRESS;
          r_mwritedata <= DWRITEDATA;
        end
      end else if (w_next == S_IDLE) begin
        r_mread  <= 1'b0;
        r_mwrite <= 1'b0;
      end
      if (w_done) r_last <= (r_state == S_DGNT);
      if (w_idone) r_ireaddata <= MREADDATA;
      if (w_ddone && r_mread) r_dreaddata <= MREADDATA;
    end
  end

  assign IREADDATA  = w_idone ? MREADDATA : r_ireaddata;
  assign DREADDATA  = (w_ddone & r_mread) ? MREADDATA : r_dreaddata;
  assign IBUSYWAIT  = w_ireq & ~w_idone;
  assign DBUSYWAIT  = w_dreq & ~w_ddone;
  assign MREAD      = r_mread;
  assign MWRITE     = r_mwrite;
  assign MADDRESS   = r_maddress;
  assign MWRITEDATA = r_mwritedata;
  assign ERROR      = r_error;

endmodule
